// File: rtl/ws2811_rx.sv
// WS2811 single-wire receiver: recovers R,G,B colour words per LED with index, frame and overflow flags.
// Define WS2811_RX_ERR_EN to add the bit_error strobe for malformed line activity.
module ws2811_rx #(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 100_000_000,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          DI,
  output logic [AW-1:0] address,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          pixel_valid,
  output logic          frame_done,
`ifdef WS2811_RX_ERR_EN
  output logic          bit_error,
`endif
  output logic          overflow
);

  localparam int US_COUNT    = SYSTEM_CLOCK / 1_000_000;
  localparam int CYCLE_COUNT = (5 * US_COUNT) / 2;
  localparam int H0          = CYCLE_COUNT / 5;
  localparam int H1          = CYCLE_COUNT / 2;
  localparam int THRESH      = (H0 + H1) / 2;
  localparam int LATCH_COUNT = 50 * US_COUNT;
  localparam int CW          = $clog2(LATCH_COUNT + 1);
  localparam int PW          = AW + 1;

  // high_cnt holds (cycles high - 1) when the fall is seen, hence >= rather than >
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [CW-1:0] LATCH_M1 = CW'(LATCH_COUNT - 1);
  localparam logic [PW-1:0] PIX_MAX  = PW'(NUM_LEDS);
`ifdef WS2811_RX_ERR_EN
  localparam logic [CW-1:0] SHORT_C  = CW'(H0 / 2 - 1);
  localparam logic [CW-1:0] STUCK_M1 = CW'(2 * CYCLE_COUNT - 1);
  localparam logic [CW-1:0] GAP_C    = CW'(2 * CYCLE_COUNT);
`endif

  // SYNC: await 50us low | IDLE: await rise | HIGH: time pulse | LOW: time gap, detect latch
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t state, state_nx;

  logic          di_s1, di_s2, di_d, rise, fall;
  logic [CW-1:0] high_cnt, low_cnt;
  logic [23:0]   sr;
  logic [4:0]    bit_idx;
  logic [PW-1:0] pix_idx;
  logic          pend;
  logic          hc_clr, hc_inc, lc_clr, lc_inc, shift_en, latch;
  logic          bit_val;
`ifdef WS2811_RX_ERR_EN
  logic          drop, err;
`endif

  assign bit_val = (high_cnt >= THRESH_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      di_s1 <= 1'b0;
      di_s2 <= 1'b0;
      di_d  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      di_s1 <= DI;
      di_s2 <= di_s1;
      di_d  <= di_s2;
      rise  <= di_s2 & ~di_d;
      fall  <= ~di_s2 & di_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SYNC: if (!di_s2 && low_cnt == LATCH_M1) state_nx = IDLE;
      IDLE: if (rise) state_nx = HIGH;
      HIGH: begin
        if (fall) state_nx = LOW;
`ifdef WS2811_RX_ERR_EN
        if (high_cnt == STUCK_M1) state_nx = SYNC;
`endif
      end
      LOW: begin
        if (rise)                     state_nx = HIGH;
        else if (low_cnt == LATCH_M1) state_nx = IDLE;
      end
      default: state_nx = SYNC;
    endcase
  end

  always_comb begin
    hc_clr   = 1'b0;
    hc_inc   = 1'b0;
    lc_clr   = 1'b0;
    lc_inc   = 1'b0;
    shift_en = 1'b0;
    latch    = 1'b0;
`ifdef WS2811_RX_ERR_EN
    drop     = 1'b0;
    err      = 1'b0;
`endif
    case (state)
      SYNC: begin
        if (di_s2) lc_clr = 1'b1;
        else       lc_inc = 1'b1;
      end
      IDLE: hc_clr = rise;
      HIGH: begin
        hc_inc = 1'b1;
        if (fall) begin
          lc_clr   = 1'b1;
          shift_en = 1'b1;
`ifdef WS2811_RX_ERR_EN
          if (high_cnt < SHORT_C) begin
            shift_en = 1'b0;
            err      = 1'b1;
          end
`endif
        end
`ifdef WS2811_RX_ERR_EN
        if (high_cnt == STUCK_M1) begin
          shift_en = 1'b0;
          lc_clr   = 1'b1;
          drop     = 1'b1;
          err      = 1'b1;
        end
`endif
      end
      LOW: begin
        lc_inc = 1'b1;
        if (rise) begin
          hc_clr = 1'b1;
`ifdef WS2811_RX_ERR_EN
          if (low_cnt > GAP_C && bit_idx != 5'd0) err = 1'b1;
`endif
        end else if (low_cnt == LATCH_M1) begin
          latch = 1'b1;
`ifdef WS2811_RX_ERR_EN
          if (bit_idx != 5'd0) err = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      high_cnt    <= '0;
      low_cnt     <= '0;
      sr          <= '0;
      bit_idx     <= '0;
      pix_idx     <= '0;
      pend        <= 1'b0;
      address     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
`ifdef WS2811_RX_ERR_EN
      bit_error   <= 1'b0;
`endif
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      pend        <= 1'b0;

      if (hc_clr)                        high_cnt <= '0;
      else if (hc_inc && high_cnt != '1) high_cnt <= high_cnt + CW'(1);

      if (lc_clr)                       low_cnt <= '0;
      else if (lc_inc && low_cnt != '1) low_cnt <= low_cnt + CW'(1);

      if (shift_en) begin
        sr <= {sr[22:0], bit_val};
        if (bit_idx == 5'd23) begin
          bit_idx <= '0;
          pend    <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 5'd1;
        end
      end

      // Publish one cycle after the 24th bit; pixels past the strip length only flag overflow
      if (pend) begin
        if (pix_idx < PIX_MAX) begin
          pixel_valid <= 1'b1;
          address     <= pix_idx[AW-1:0];
          red         <= sr[23:16];
          green       <= sr[15:8];
          blue        <= sr[7:0];
          pix_idx     <= pix_idx + PW'(1);
        end else begin
          overflow    <= 1'b1;
        end
      end

      if (latch) begin
        frame_done <= 1'b1;
        bit_idx    <= '0;
        pix_idx    <= '0;
        overflow   <= 1'b0;
      end

`ifdef WS2811_RX_ERR_EN
      bit_error <= err;
      if (drop) begin
        bit_idx <= '0;
        pix_idx <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ws2811_rx.sv
// Randomized line-level stimulus for ws2811_rx; a frame-level reference model feeds a scoreboard
// that a separate monitor drains whenever pixel_valid or frame_done fires.
module tb_ws2811_rx;

  localparam int NUM_LEDS     = 4;
  localparam int SYSTEM_CLOCK = 100_000_000;
  localparam int AW           = $clog2(NUM_LEDS);
  localparam int US           = SYSTEM_CLOCK / 1_000_000;
  localparam int CELL         = (5 * US) / 2;
  localparam int THRESH       = (CELL / 5 + CELL / 2) / 2;
  localparam int LATCH        = 50 * US;
  // Edge counts from the drive instant of the final falling edge; the next edge is the first to sample it
  localparam int PIX_LAT      = 1 + 4;
  localparam int FRAME_LAT    = 1 + 3 + LATCH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          DI = 1'b0;
  logic [AW-1:0] address;
  logic [7:0]    red, green, blue;
  logic          pixel_valid, frame_done, overflow;
`ifdef WS2811_RX_ERR_EN
  logic          bit_error;
`endif

  ws2811_rx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(SYSTEM_CLOCK)) dut (
    .clk(clk),
    .reset(reset),
    .DI(DI),
    .address(address),
    .red(red),
    .green(green),
    .blue(blue),
    .pixel_valid(pixel_valid),
    .frame_done(frame_done),
`ifdef WS2811_RX_ERR_EN
    .bit_error(bit_error),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   rgb;
    int            due;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_frame[$];
  int   nvec = 0;
  int   nerr = 0;

  // Reference model: protocol-level view of what the receiver should report
  bit          synced = 1'b0;
  int          nbits = 0;
  int          pix = 0;
  int          frame_bits = 0;
  logic [23:0] word = '0;
  bit          ovf = 1'b0;
  int          fall_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_address"}, 32'(address), 32'd0);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
  endtask

  task automatic model_bit(input bit b);
    pix_t p;
    if (!synced) return;
    frame_bits++;
    word = {word[22:0], b};
    nbits++;
    if (nbits == 24) begin
      nbits = 0;
      if (pix < NUM_LEDS) begin
        p.addr = AW'(pix);
        p.rgb  = word;
        p.due  = fall_edge + PIX_LAT;
        exp_pix.push_back(p);
      end else begin
        ovf = 1'b1;
      end
      pix++;
    end
  endtask

  task automatic send_bit(input int h, input int lo);
    DI = 1'b1;
    repeat (h) @(negedge clk);
    DI = 1'b0;
    fall_edge = edge_cnt;
    model_bit(h > THRESH);
    repeat (lo) @(negedge clk);
  endtask

  // mode 0: nominal 50/125 highs on 250 cells; 1: random highs, short gaps; 2: highs one off the threshold
  task automatic send_pixel(input logic [23:0] rgb, input int mode, input int nb);
    int h;
    int lo;
    for (int i = 23; i > 23 - nb; i--) begin
      case (mode)
        0: begin
          h  = rgb[i] ? 125 : 50;
          lo = CELL - h;
        end
        1: begin
          h  = rgb[i] ? int'($urandom_range(THRESH + 1, 150)) : int'($urandom_range(30, THRESH));
          lo = int'($urandom_range(10, 30));
        end
        default: begin
          h  = rgb[i] ? THRESH + 1 : THRESH - 1;
          lo = int'($urandom_range(10, 30));
        end
      endcase
      send_bit(h, lo);
    end
  endtask

  task automatic send_gap(input int cycles);
    if (cycles >= LATCH) begin
      if (synced && frame_bits > 0) exp_frame.push_back(fall_edge + FRAME_LAT);
      frame_bits = 0;
      nbits      = 0;
      pix        = 0;
      ovf        = 1'b0;
      synced     = 1'b1;
    end
    repeat (cycles) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    check_cleared("midreset");
    reset      = 1'b0;
    synced     = 1'b0;
    frame_bits = 0;
    nbits      = 0;
    pix        = 0;
    ovf        = 1'b0;
  endtask

  always @(negedge clk) begin
    pix_t e;
    int   fd;
    if (pixel_valid) begin
      nvec++;
      if (exp_pix.size() == 0) begin
        nerr++;
        $display("FAIL pixel_unexpected: got addr=%0d rgb=%06h edge=%0d, required no strobe",
                 address, {red, green, blue}, edge_cnt);
      end else begin
        e = exp_pix.pop_front();
        if (address !== e.addr || {red, green, blue} !== e.rgb || edge_cnt != e.due) begin
          nerr++;
          $display("FAIL pixel: got addr=%0d rgb=%06h edge=%0d, required addr=%0d rgb=%06h edge=%0d",
                   address, {red, green, blue}, edge_cnt, e.addr, e.rgb, e.due);
        end
      end
    end else if (exp_pix.size() > 0 && edge_cnt > exp_pix[0].due) begin
      e = exp_pix.pop_front();
      nvec++;
      nerr++;
      $display("FAIL pixel_missing: got no strobe by edge %0d, required addr=%0d rgb=%06h at edge %0d",
               edge_cnt, e.addr, e.rgb, e.due);
    end

    if (frame_done) begin
      nvec++;
      if (exp_frame.size() == 0) begin
        nerr++;
        $display("FAIL frame_unexpected: got strobe at edge %0d, required none", edge_cnt);
      end else begin
        fd = exp_frame.pop_front();
        if (edge_cnt != fd) begin
          nerr++;
          $display("FAIL frame_done: got edge %0d, required edge %0d", edge_cnt, fd);
        end
      end
    end else if (exp_frame.size() > 0 && edge_cnt > exp_frame[0]) begin
      fd = exp_frame.pop_front();
      nvec++;
      nerr++;
      $display("FAIL frame_missing: got no strobe by edge %0d, required at edge %0d", edge_cnt, fd);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by time %0t, required end of sequence", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    DI    = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    // Startup sync, then a nominal pixel followed by three random ones
    send_gap(6000);
    send_pixel(24'hFF00A5, 0, 24);
    repeat (3) send_pixel(24'($urandom), 1, 24);
    check("ovf_full_frame", 32'(overflow), 32'(ovf));
    send_gap(5500);
    check("ovf_after_frame", 32'(overflow), 32'(ovf));

    // Overflow frame, first two pixels straddle the threshold by one cycle
    repeat (2) send_pixel(24'($urandom), 2, 24);
    repeat (2) send_pixel(24'($urandom), 1, 24);
    check("ovf_at_limit", 32'(overflow), 32'(ovf));
    send_pixel(24'($urandom), 1, 24);
    check("ovf_set", 32'(overflow), 32'(ovf));
    send_gap(5500);
    check("ovf_cleared", 32'(overflow), 32'(ovf));

    // Pixel, then partial pixel dropped at the latch
    send_pixel(24'($urandom), 1, 24);
    send_pixel(24'($urandom), 1, 12);
    send_gap(6000);

    // Reset mid-pixel, unsynchronised pixel ignored, then recovery
    send_pixel(24'h5AC37E, 1, 24);
    send_pixel(24'($urandom), 1, 10);
    apply_reset();
    send_pixel(24'($urandom), 1, 24);
    send_gap(6000);
    send_pixel(24'($urandom), 1, 24);
    send_gap(5500);

    repeat (20) @(negedge clk);
    check("pixel_queue_drained", 32'(exp_pix.size()), 32'd0);
    check("frame_queue_drained", 32'(exp_frame.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
